pattern_scan_ctrl: RTL and testbench

Frame-level controller that streams parallel data words, MSB first, through an internal overlapping "1101" Moore detector. It counts pattern matches per frame and records the bit position of the first match. The detector context carries across word boundaries within a frame and is cleared between frames. It sits between a word-wide producer (valid/ready) and status logic that consumes a one-cycle `done` pulse with the frame results.

---
 rtl/pattern_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: streams words MSB-first through an overlapping "1101"
// Moore detector and reports per-frame match count and first-match position.
// Optional feature macro: SCAN_ABORT_EN adds the abort input.
module pattern_scan_ctrl #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned POS_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic [CNT_W-1:0]  match_count,
  output logic [POS_W-1:0]  first_pos,
  output logic              first_valid,
  output logic              done
`ifdef SCAN_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam int unsigned BC_W = $clog2(WORD_W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_e;
  typedef enum logic [2:0] {D0, D1, D2, D3, D4} det_e;

  state_e              state_q, state_d;
  det_e                det_q, det_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [POS_W-1:0]    bit_idx_q, bit_idx_d;
  logic                last_q, last_d;
  logic                fed_q, fed_d;
  logic                start_q, start_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [POS_W-1:0]    fpos_q, fpos_d;
  logic                fval_q, fval_d;
  logic                in_ready_q, in_ready_d;
  logic                done_q, done_d;
  logic                abort_c;
  logic                kill_c;
  logic                accept_c;

`ifdef SCAN_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Overlapping "1101" Moore transition function
  function automatic det_e det_next(input det_e s, input logic b);
    det_e n;
    n = D0;
    case (s)
      D0:      n = b ? D1 : D0;
      D1:      n = b ? D2 : D0;
      D2:      n = b ? D2 : D3;
      D3:      n = b ? D4 : D0;
      D4:      n = b ? D2 : D0;
      default: n = D0;
    endcase
    return n;
  endfunction

  // Abort is honoured only while a frame is in progress
  assign kill_c   = abort_c && ((state_q == S_SHIFT) || (state_q == S_DRAIN) ||
                                ((state_q == S_IDLE) && !start_q));
  assign accept_c = in_valid && in_ready_q && !kill_c;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    det_d     = det_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    last_d    = last_q;
    fed_d     = 1'b0;
    start_d   = start_q;
    cnt_d     = cnt_q;
    fpos_d    = fpos_q;
    fval_d    = fval_q;

    // Hit from the bit consumed on the previous edge
    if (fed_q && (det_q == D4)) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      if (!fval_q) begin
        fval_d = 1'b1;
        fpos_d = bit_idx_q - POS_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept_c) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        det_d     = det_next(det_q, shift_q[WORD_W-1]);
        fed_d     = 1'b1;
        shift_d   = shift_q << 1;
        bit_idx_d = bit_idx_q + POS_W'(1);
        if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - BC_W'(1);
        end else if (!accept_c) begin
          state_d = last_q ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        start_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Word load; a frame start also clears detector context and results
    if (accept_c) begin
      shift_d   = in_data;
      bit_cnt_d = BC_W'(WORD_W - 1);
      last_d    = in_last;
      if (start_q) begin
        start_d   = 1'b0;
        det_d     = D0;
        bit_idx_d = '0;
        cnt_d     = '0;
        fval_d    = 1'b0;
      end
    end

    if (kill_c) begin
      state_d   = S_IDLE;
      det_d     = D0;
      fed_d     = 1'b0;
      bit_cnt_d = '0;
      bit_idx_d = '0;
      last_d    = 1'b0;
      start_d   = 1'b1;
      cnt_d     = '0;
      fpos_d    = '0;
      fval_d    = 1'b0;
    end

    in_ready_d = (state_d == S_IDLE) ||
                 ((state_d == S_SHIFT) && (bit_cnt_d == '0) && !last_d);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      det_q      <= D0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      last_q     <= 1'b0;
      fed_q      <= 1'b0;
      start_q    <= 1'b1;
      cnt_q      <= '0;
      fpos_q     <= '0;
      fval_q     <= 1'b0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      det_q      <= det_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      last_q     <= last_d;
      fed_q      <= fed_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      fpos_q     <= fpos_d;
      fval_q     <= fval_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign done        = done_q;
  assign match_count = cnt_q;
  assign first_pos   = fpos_q;
  assign first_valid = fval_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed self-checking bench for pattern_scan_ctrl (default and CNT_W=2).
module tb_pattern_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready, in_ready_s;
  logic [7:0]  match_count;
  logic [1:0]  match_count_s;
  logic [15:0] first_pos, first_pos_s;
  logic        first_valid, first_valid_s;
  logic        done, done_s;
`ifdef SCAN_ABORT_EN
  logic        abort;
`endif

  int tests = 0;
  int fails = 0;
  int edges;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.WORD_W(8), .CNT_W(8), .POS_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .match_count(match_count),
    .first_pos(first_pos), .first_valid(first_valid), .done(done)
`ifdef SCAN_ABORT_EN
    , .abort(abort)
`endif
  );

  pattern_scan_ctrl #(.WORD_W(8), .CNT_W(2), .POS_W(16)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .match_count(match_count_s),
    .first_pos(first_pos_s), .first_valid(first_valid_s), .done(done_s)
`ifdef SCAN_ABORT_EN
    , .abort(abort)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until accepted; edges includes the accepting edge
  task automatic send(input logic [7:0] d, input logic l, output int n);
    logic rdy;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (n < 100) begin
      rdy = in_ready;
      tick();
      n++;
      if (rdy) break;
    end
    if (n >= 100) n = -1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Count edges until done is seen high; -1 if the budget runs out
  task automatic wait_done(output int n);
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (done) break;
    end
    if (!done) n = -1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
`ifdef SCAN_ABORT_EN
    abort    = 1'b0;
`endif
    #12;
    reset = 1'b0;

    // Reset state
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_done",  32'(done), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_fval",  32'(first_valid), 32'd0);

    // Single word 0xDB: two matches, first at bit 3, done after E9
    send(8'hDB, 1'b1, edges);
    check("w1_accept", 32'(edges), 32'd1);
    check("w1_busy_ready", 32'(in_ready), 32'd0);
    wait_done(edges);
    check("w1_latency", 32'(edges), 32'd9);
    check("w1_count", 32'(match_count), 32'd2);
    check("w1_fpos",  32'(first_pos), 32'd3);
    check("w1_fval",  32'(first_valid), 32'd1);
    tick();
    check("w1_done_pulse", 32'(done), 32'd0);
    check("w1_ready_after", 32'(in_ready), 32'd1);
    repeat (3) tick();
    check("w1_hold_count", 32'(match_count), 32'd2);

    // Cross-boundary 0x01 then 0xA0: match at bit 10, no bubble
    send(8'h01, 1'b0, edges);
    check("xb_accept0", 32'(edges), 32'd1);
    check("xb_cleared", 32'(match_count), 32'd0);
    send(8'hA0, 1'b1, edges);
    check("xb_accept1_edge", 32'(edges), 32'd8);
    wait_done(edges);
    check("xb_latency", 32'(edges), 32'd9);
    check("xb_count", 32'(match_count), 32'd1);
    check("xb_fpos",  32'(first_pos), 32'd10);
    tick();

    // Gap hold: 0x0D, idle gap, 0x00 last: exactly one count
    send(8'h0D, 1'b0, edges);
    repeat (13) tick();
    check("gap_count_mid", 32'(match_count), 32'd1);
    send(8'h00, 1'b1, edges);
    check("gap_accept", 32'(edges), 32'd1);
    wait_done(edges);
    check("gap_latency", 32'(edges), 32'd9);
    check("gap_count", 32'(match_count), 32'd1);
    check("gap_fpos",  32'(first_pos), 32'd7);
    tick();

    // No-match frame: first_valid cleared, first_pos retained
    send(8'h00, 1'b1, edges);
    wait_done(edges);
    check("nm_count", 32'(match_count), 32'd0);
    check("nm_fval",  32'(first_valid), 32'd0);
    check("nm_fpos",  32'(first_pos), 32'd7);
    tick();

    // Saturation: 0xDD, 0xDD gives 4 hits
    send(8'hDD, 1'b0, edges);
    send(8'hDD, 1'b1, edges);
    wait_done(edges);
    check("sat_latency", 32'(edges), 32'd9);
    check("sat_count_w2", 32'(match_count_s), 32'd3);
    check("sat_fpos_w2",  32'(first_pos_s), 32'd3);
    check("sat_done_w2",  32'(done_s), 32'd1);
    check("sat_count_w8", 32'(match_count), 32'd4);
    tick();

    // Reset during the third bit of 0xFF
    send(8'hFF, 1'b1, edges);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mr_ready", 32'(in_ready), 32'd1);
    check("mr_done",  32'(done), 32'd0);
    check("mr_count", 32'(match_count_s), 32'd0);
    check("mr_fpos",  32'(first_pos), 32'd0);
    check("mr_fval",  32'(first_valid), 32'd0);
    #2;
    reset = 1'b0;
    tick();
    send(8'h0D, 1'b1, edges);
    wait_done(edges);
    check("mr_next_latency", 32'(edges), 32'd9);
    check("mr_next_count", 32'(match_count), 32'd1);
    check("mr_next_fpos",  32'(first_pos), 32'd7);
    tick();

`ifdef SCAN_ABORT_EN
    // Abort in SHIFT after one hit was already counted
    send(8'hDB, 1'b1, edges);
    repeat (5) tick();
    check("ab_pre_count", 32'(match_count), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_count", 32'(match_count), 32'd0);
    check("ab_fval",  32'(first_valid), 32'd0);
    check("ab_ready", 32'(in_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      repeat (12) begin
        tick();
        if (done) seen++;
      end
      check("ab_no_done", 32'(seen), 32'd0);
    end
    // Abort beats a simultaneous handshake
    send(8'h0D, 1'b0, edges);
    repeat (8) tick();
    in_valid = 1'b1;
    in_data  = 8'hDB;
    in_last  = 1'b1;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("ab_hs_ready", 32'(in_ready), 32'd1);
    check("ab_hs_count", 32'(match_count), 32'd0);
    send(8'hDB, 1'b1, edges);
    wait_done(edges);
    check("ab_after_count", 32'(match_count), 32'd2);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
